// File: rtl/pcpi_initiator.sv
// pcpi_initiator: core-side PCPI shim. Takes one command over a
// valid/ready handshake, drives it onto the PCPI bus, waits for the
// coprocessor to finish and returns rd/wr (or a trap) on a response
// handshake.
// Ports:
//   clkIn, rstIn (async, active-high)
//   cmdValidIn/cmdReadyOut, cmdInstIn, cmdRs1In, cmdRs2In : command in
//   pcipValidOut, pcipInstOut, pcipRs1Out, pcipRs2Out     : PCPI request
//   pcipWrIn, pcipRdIn, pcipWaitIn, pcipReadyIn          : PCPI reply
//   rspValidOut/rspReadyIn, rspDataOut, rspWrOut, rspTrapOut : response
// Macro PCPI_TIMEOUT_EN: adds the no-responder timeout and trap path.
module pcpi_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        cmdValidIn,
  output logic        cmdReadyOut,
  input  logic [31:0] cmdInstIn,
  input  logic [31:0] cmdRs1In,
  input  logic [31:0] cmdRs2In,
  output logic        pcipValidOut,
  output logic [31:0] pcipInstOut,
  output logic [31:0] pcipRs1Out,
  output logic [31:0] pcipRs2Out,
  input  logic        pcipWrIn,
  input  logic [31:0] pcipRdIn,
  input  logic        pcipWaitIn,
  input  logic        pcipReadyIn,
  output logic        rspValidOut,
  input  logic        rspReadyIn,
  output logic [31:0] rspDataOut,
  output logic        rspWrOut,
  output logic        rspTrapOut
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q;
  logic        pv_q;
  logic [31:0] inst_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic        rv_q;
  logic [31:0] rd_q;
  logic        wr_q;

`ifdef PCPI_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] CntLast =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 trap_q;
`endif

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state_q <= IDLE;
      pv_q    <= 1'b0;
      inst_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
`ifdef PCPI_TIMEOUT_EN
      cnt_q   <= '0;
      trap_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmdValidIn) begin
            inst_q  <= cmdInstIn;
            rs1_q   <= cmdRs1In;
            rs2_q   <= cmdRs2In;
            pv_q    <= 1'b1;
            state_q <= ACTIVE;
`ifdef PCPI_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ACTIVE: begin
          // ready beats a simultaneous timeout
          if (pcipReadyIn) begin
            rd_q    <= pcipRdIn;
            wr_q    <= pcipWrIn;
            pv_q    <= 1'b0;
            rv_q    <= 1'b1;
            state_q <= RESP;
`ifdef PCPI_TIMEOUT_EN
            trap_q  <= 1'b0;
          end else if (pcipWaitIn) begin
            // a busy coprocessor has claimed it
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            rd_q    <= '0;
            wr_q    <= 1'b0;
            trap_q  <= 1'b1;
            pv_q    <= 1'b0;
            rv_q    <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end
        RESP: begin
          if (rspReadyIn) begin
            rv_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          pv_q    <= 1'b0;
          rv_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmdReadyOut  = (state_q == IDLE);
  assign pcipValidOut = pv_q;
  assign pcipInstOut  = inst_q;
  assign pcipRs1Out   = rs1_q;
  assign pcipRs2Out   = rs2_q;
  assign rspValidOut  = rv_q;
  assign rspDataOut   = rd_q;
  assign rspWrOut     = wr_q;

`ifdef PCPI_TIMEOUT_EN
  assign rspTrapOut   = trap_q;
`else
  // without the timeout, wait and the counter sizing play no role
  logic unused_cfg;
  assign unused_cfg   = pcipWaitIn ^
                        (TIMEOUT_CYCLES > CNT_WIDTH);
  assign rspTrapOut   = 1'b0;
`endif

endmodule

// File: tb/tb_pcpi_initiator.sv
// tb_pcpi_initiator: random + directed transactions against a
// transaction-level model of the PCPI initiator.
module tb_pcpi_initiator;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rstIn;
  logic        cmdValidIn;
  logic        cmdReadyOut;
  logic [31:0] cmdInstIn;
  logic [31:0] cmdRs1In;
  logic [31:0] cmdRs2In;
  logic        pcipValidOut;
  logic [31:0] pcipInstOut;
  logic [31:0] pcipRs1Out;
  logic [31:0] pcipRs2Out;
  logic        pcipWrIn;
  logic [31:0] pcipRdIn;
  logic        pcipWaitIn;
  logic        pcipReadyIn;
  logic        rspValidOut;
  logic        rspReadyIn;
  logic [31:0] rspDataOut;
  logic        rspWrOut;
  logic        rspTrapOut;

  int errors = 0;
  int checks = 0;

  pcpi_initiator #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_WIDTH(5)
  ) dut (
    .clkIn(clk),
    .rstIn(rstIn),
    .cmdValidIn(cmdValidIn),
    .cmdReadyOut(cmdReadyOut),
    .cmdInstIn(cmdInstIn),
    .cmdRs1In(cmdRs1In),
    .cmdRs2In(cmdRs2In),
    .pcipValidOut(pcipValidOut),
    .pcipInstOut(pcipInstOut),
    .pcipRs1Out(pcipRs1Out),
    .pcipRs2Out(pcipRs2Out),
    .pcipWrIn(pcipWrIn),
    .pcipRdIn(pcipRdIn),
    .pcipWaitIn(pcipWaitIn),
    .pcipReadyIn(pcipReadyIn),
    .rspValidOut(rspValidOut),
    .rspReadyIn(rspReadyIn),
    .rspDataOut(rspDataOut),
    .rspWrOut(rspWrOut),
    .rspTrapOut(rspTrapOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full command: accept, coprocessor script, response, consume.
  // The coprocessor holds wait for wait_n cycles, then idles for
  // gap_n cycles, then pulses ready (if respond).
  task automatic run_txn(input logic [31:0] insn,
                         input logic [31:0] rs1,
                         input logic [31:0] rs2,
                         input int          wait_n,
                         input int          gap_n,
                         input bit          respond,
                         input logic [31:0] rd,
                         input bit          wr,
                         input int          hold);
    int  run;
    int  c;
    bit  done;
    bit  trap;
    logic [31:0] exp_d;
    logic        exp_w;
    chk("cmd_rdy_idle", cmdReadyOut, 1);
    cmdValidIn = 1'b1;
    cmdInstIn  = insn;
    cmdRs1In   = rs1;
    cmdRs2In   = rs2;
    step();
    chk("pv_accept", pcipValidOut, 1);
    chk("pcip_inst", pcipInstOut, insn);
    chk("pcip_rs1", pcipRs1Out, rs1);
    chk("pcip_rs2", pcipRs2Out, rs2);
    chk("cmd_rdy_busy", cmdReadyOut, 0);
    cmdValidIn = 1'b0;
    cmdInstIn  = $urandom;
    cmdRs1In   = $urandom;
    cmdRs2In   = $urandom;
    run  = 0;
    c    = 0;
    done = 1'b0;
    trap = 1'b0;
    while (!done) begin
      pcipWaitIn  = (c < wait_n);
      pcipReadyIn = respond && (c == wait_n + gap_n);
      pcipRdIn    = pcipReadyIn ? rd : $urandom;
      pcipWrIn    = pcipReadyIn ? wr : 1'($urandom);
      step();
      if (pcipReadyIn) begin
        done = 1'b1;
      end else begin
        if (pcipWaitIn) run = 0;
        else run++;
`ifdef PCPI_TIMEOUT_EN
        if (run == TMO) begin
          done = 1'b1;
          trap = 1'b1;
        end
`endif
      end
      c++;
      if (!done) begin
        chk("pv_active", pcipValidOut, 1);
        chk("rv_active", rspValidOut, 0);
        if (c > 300) begin
          chk("active_budget", c, 300);
          done = 1'b1;
        end
      end
    end
    pcipReadyIn = 1'b0;
    pcipWaitIn  = 1'b0;
    exp_d = trap ? 32'h0 : rd;
    exp_w = trap ? 1'b0 : wr;
    chk("rsp_valid", rspValidOut, 1);
    chk("rsp_data", rspDataOut, exp_d);
    chk("rsp_wr", rspWrOut, exp_w);
    chk("rsp_trap", rspTrapOut, trap);
    chk("pv_resp", pcipValidOut, 0);
    chk("cmd_rdy_resp", cmdReadyOut, 0);
    cmdValidIn = 1'b1;
    for (int h = 0; h < hold; h++) begin
      pcipReadyIn = 1'($urandom);
      pcipRdIn    = $urandom;
      rspReadyIn  = 1'b0;
      step();
      chk("hold_rv", rspValidOut, 1);
      chk("hold_data", rspDataOut, exp_d);
      chk("hold_trap", rspTrapOut, trap);
      chk("hold_cmdrdy", cmdReadyOut, 0);
      chk("hold_pv", pcipValidOut, 0);
      chk("hold_inst", pcipInstOut, insn);
    end
    cmdValidIn  = 1'b0;
    pcipReadyIn = 1'b0;
    rspReadyIn  = 1'b1;
    step();
    rspReadyIn  = 1'b0;
    chk("consume_rv", rspValidOut, 0);
    chk("consume_cmdrdy", cmdReadyOut, 1);
  endtask

  initial begin
    rstIn       = 1'b1;
    cmdValidIn  = 1'b0;
    cmdInstIn   = '0;
    cmdRs1In    = '0;
    cmdRs2In    = '0;
    pcipWrIn    = 1'b0;
    pcipRdIn    = '0;
    pcipWaitIn  = 1'b0;
    pcipReadyIn = 1'b0;
    rspReadyIn  = 1'b0;
    repeat (3) step();
    rstIn = 1'b0;
    step();
    chk("rst_cmdrdy", cmdReadyOut, 1);
    chk("rst_pv", pcipValidOut, 0);
    chk("rst_inst", pcipInstOut, 0);
    chk("rst_rs1", pcipRs1Out, 0);
    chk("rst_rs2", pcipRs2Out, 0);
    chk("rst_rv", rspValidOut, 0);
    chk("rst_data", rspDataOut, 0);
    chk("rst_wr", rspWrOut, 0);
    chk("rst_trap", rspTrapOut, 0);

    // fmul.s 2.0 * 3.0 = 6.0
    run_txn(32'h102081D3, 32'h40000000, 32'h40400000,
            2, 1, 1'b1, 32'h40C00000, 1'b1, 0);
    // long busy coprocessor
    run_txn(32'h0200_0033, $urandom, $urandom,
            40, 0, 1'b1, 32'hDEADBEEF, 1'b1, 0);
    // response backpressure with a new command pending
    run_txn($urandom, $urandom, $urandom,
            0, 0, 1'b1, 32'h1234_5678, 1'b0, 5);
`ifdef PCPI_TIMEOUT_EN
    // nobody answers
    run_txn(32'h00000013, $urandom, $urandom,
            0, 0, 1'b0, 32'h0, 1'b0, 1);
    // ready on the last idle cycle wins over the trap
    run_txn($urandom, $urandom, $urandom,
            0, TMO - 1, 1'b1, 32'hCAFE_F00D, 1'b1, 0);
    // one idle cycle too many
    run_txn($urandom, $urandom, $urandom,
            0, TMO, 1'b1, 32'hCAFE_F00D, 1'b1, 0);
`endif

    for (int t = 0; t < 30; t++) begin
`ifdef PCPI_TIMEOUT_EN
      run_txn($urandom, $urandom, $urandom,
              $urandom_range(0, 20), $urandom_range(0, 25),
              1'($urandom_range(0, 3) != 0), $urandom,
              1'($urandom), $urandom_range(0, 3));
`else
      run_txn($urandom, $urandom, $urandom,
              $urandom_range(0, 20), $urandom_range(0, 25),
              1'b1, $urandom,
              1'($urandom), $urandom_range(0, 3));
`endif
    end

    // reset in the middle of an operation
    cmdValidIn = 1'b1;
    cmdInstIn  = $urandom;
    step();
    cmdValidIn = 1'b0;
    repeat (3) step();
    chk("mid_pv_before", pcipValidOut, 1);
    #2;
    rstIn = 1'b1;
    #1;
    chk("mid_pv_async", pcipValidOut, 0);
    chk("mid_rv_async", rspValidOut, 0);
    pcipReadyIn = 1'b1;
    pcipRdIn    = 32'hBAD0_BAD0;
    step();
    rstIn = 1'b0;
    step();
    pcipReadyIn = 1'b0;
    chk("mid_cmdrdy", cmdReadyOut, 1);
    chk("mid_rv", rspValidOut, 0);
    chk("mid_pv", pcipValidOut, 0);
    step();
    chk("mid_rv_later", rspValidOut, 0);
    run_txn($urandom, $urandom, $urandom,
            3, 2, 1'b1, 32'h0F0F_0F0F, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
